memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the execute stage. Consumes the execute result (address or ALU/MUL
//  value), store data and control from the EX/MEM boundary and runs a req/gnt/rvalid handshake to data memory.
//  Stalls the pipeline while an access is outstanding. Drives the registered MEM/WB boundary consumed by writeback
//  and by the execute-stage forwarding path (execute_out_w).
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles in REQ or RESP before an access is abandoned; legal range 2..255
// PORTS
//  clk                  in   1   rising-edge clock
//  rst                  in   1   synchronous, active-high reset
//  valid_m              in   1   instruction present in MEM
//  flush_m              in   1   kill the MEM instruction; honoured in IDLE only
//  execute_out_m        in   32  execute result; byte address when dmem_read_en_m or dmem_write_en_m is set
//  reg_readdata2_m      in   32  store data
//  dmem_read_en_m       in   1   load
//  dmem_write_en_m      in   1   store
//  reg_write_addr_m     in   5   destination register
//  reg_write_en_m       in   1   destination write enable
//  reg_writedata_sel_m  in   1   writeback select: 1 = load data, 0 = execute result
//  stall_m              out  1   hold IF..EX and the EX/MEM inputs; combinational
//  dmem_req             out  1   memory request
//  dmem_we              out  1   1 = write
//  dmem_addr            out  32  word-aligned address (execute_out_m with [1:0] forced to 0)
//  dmem_wdata           out  32  store data
//  dmem_gnt             in   1   request accepted this cycle
//  dmem_rvalid          in   1   read data valid
//  dmem_rdata           in   32  read data
//  valid_w              out  1   MEM/WB valid
//  execute_out_w        out  32  registered execute result
//  dmem_readdata_w      out  32  registered load data
//  reg_write_addr_w     out  5   registered destination register
//  reg_write_en_w       out  1   registered write enable; forced to 0 on error or kill
//  reg_writedata_sel_w  out  1   registered writeback select
//  mem_err_w            out  1   one-cycle pulse, aligned with valid_w: misaligned, illegal or timed-out access
// BEHAVIOUR
//  Reset: every output is 0, FSM state is IDLE and the timeout counter is 0.
//  FSM states: IDLE, REQ, RESP.
//  Definitions:
//   - mem_op = valid_m & !flush_m & (dmem_read_en_m | dmem_write_en_m).
//   - bad = both enables set, or execute_out_m[1:0] != 0.
//  IDLE, no mem_op: MEM/WB loads at the next edge; stall_m = 0; valid_w = valid_m & !flush_m.
//  IDLE, mem_op & bad:
//   - no request is issued; stall_m = 0.
//   - MEM/WB loads next edge with valid_w = 1, reg_write_en_w = 0, mem_err_w = 1.
//  IDLE, mem_op & !bad:
//   - dmem_req = 1 combinationally; dmem_we, dmem_addr and dmem_wdata come from the current inputs.
//   - Store with dmem_gnt = 1: done; stall_m = 0; MEM/WB loads next edge.
//   - Load with dmem_gnt = 1: stall_m = 1; next state RESP.
//   - Either with dmem_gnt = 0: stall_m = 1; next state REQ.
//  REQ:
//   - dmem_req stays 1 with stable address, data and we (inputs are held stable by stall_m).
//   - On dmem_gnt, a store completes exactly as in IDLE; a load goes to RESP.
//  RESP:
//   - dmem_req = 0; stall_m = !dmem_rvalid.
//   - On dmem_rvalid: dmem_readdata_w <= dmem_rdata, MEM/WB loads, next state IDLE.
//   - dmem_rvalid outside RESP is ignored.
//  Latency:
//   - Non-memory op and store with immediate grant: 1 cycle, no stall.
//   - Load with immediate grant and rvalid the next cycle: exactly 1 stall cycle.
//  Timeout:
//   - The counter increments every cycle spent in REQ or RESP and clears on entry to IDLE.
//   - At TIMEOUT_CYCLES-1: abandon the access and return to IDLE; stall_m = 0 that cycle.
//   - MEM/WB then loads with valid_w = 1, reg_write_en_w = 0, mem_err_w = 1.
//  flush_m in REQ or RESP is ignored; the bus transaction is always completed or timed out.
//  MEM/WB hold rule: while stall_m = 1, MEM/WB loads a bubble (valid_w = 0, reg_write_en_w = 0, mem_err_w = 0).
//   The other _w fields hold their values.
//  rst asserted mid-access: next state is IDLE, dmem_req drops the next cycle, no response is awaited.
// TESTING
//  ALU op, execute_out_m = 0x1234, reg_write_en_m = 1 -> next cycle valid_w = 1, execute_out_w = 0x1234, no stall.
//  Store to 0x100, data 0xDEADBEEF, gnt same cycle -> dmem_req/we for 1 cycle, stall_m = 0, reg_write_en_w = 0.
//  Load from 0x200, gnt after 3 cycles, rvalid 2 cycles later with 0xCAFEF00D -> stall_m high 5 cycles.
//   Then dmem_readdata_w = 0xCAFEF00D with valid_w = 1.
//  Load from 0x202 (misaligned) -> dmem_req never asserted; mem_err_w = 1, reg_write_en_w = 0 next cycle.
//  Load, gnt given, rvalid never arrives, TIMEOUT_CYCLES = 8 -> stall released on the 8th cycle; mem_err_w = 1.
//  rst asserted while in RESP -> all outputs 0 next cycle; a late dmem_rvalid is ignored; the next ALU op proceeds normally.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage between execute and writeback.
// Runs a req/gnt/rvalid handshake to data memory, stalls the front of the
// pipeline while an access is outstanding, abandons accesses that take too
// long and presents a registered MEM/WB boundary to writeback and to the
// execute-stage forwarding path.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM boundary
  input  logic        valid_m,
  input  logic        flush_m,
  input  logic [31:0] execute_out_m,
  input  logic [31:0] reg_readdata2_m,
  input  logic        dmem_read_en_m,
  input  logic        dmem_write_en_m,
  input  logic [4:0]  reg_write_addr_m,
  input  logic        reg_write_en_m,
  input  logic        reg_writedata_sel_m,
  output logic        stall_m,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  // MEM/WB boundary
  output logic        valid_w,
  output logic [31:0] execute_out_w,
  output logic [31:0] dmem_readdata_w,
  output logic [4:0]  reg_write_addr_w,
  output logic        reg_write_en_w,
  output logic        reg_writedata_sel_w,
  output logic        mem_err_w
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Last counter value before an access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  logic        mem_op_s;     // live memory instruction in MEM
  logic        bad_s;        // misaligned or both enables set
  logic        tmo_hit_s;    // access has used its whole cycle budget
  logic        req_s;        // drive a request this cycle
  logic        stall_s;      // hold the upstream stages
  logic        wb_valid_s;   // MEM/WB valid to load when not stalled
  logic        wb_we_s;      // MEM/WB write enable to load when not stalled
  logic        wb_err_s;     // MEM/WB error pulse to load when not stalled
  logic        rdata_ld_s;   // capture read data into MEM/WB

  // MEM/WB boundary registers
  logic        valid_q;
  logic [31:0] execute_out_q;
  logic [31:0] dmem_readdata_q;
  logic [4:0]  reg_write_addr_q;
  logic        reg_write_en_q;
  logic        reg_writedata_sel_q;
  logic        mem_err_q;

  // Decode the incoming instruction and the timeout condition.
  always_comb begin
    mem_op_s  = valid_m & ~flush_m & (dmem_read_en_m | dmem_write_en_m);
    bad_s     = (dmem_read_en_m & dmem_write_en_m) | (execute_out_m[1:0] != 2'b00);
    tmo_hit_s = (tmo_cnt_q == TMO_LAST);
  end

  // Next-state logic and per-cycle handshake/stall/writeback decisions.
  always_comb begin
    state_d    = state_q;
    req_s      = 1'b0;
    stall_s    = 1'b0;
    wb_valid_s = 1'b0;
    wb_we_s    = 1'b0;
    wb_err_s   = 1'b0;
    rdata_ld_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!mem_op_s) begin
          // plain ALU/MUL result, bubble, or flushed instruction
          wb_valid_s = valid_m & ~flush_m;
          wb_we_s    = valid_m & ~flush_m & reg_write_en_m;
        end else if (bad_s) begin
          // never reaches the bus; retire with an error and no register write
          wb_valid_s = 1'b1;
          wb_err_s   = 1'b1;
        end else begin
          req_s = 1'b1;
          if (dmem_gnt && dmem_write_en_m) begin
            // store accepted immediately: retires without stalling
            wb_valid_s = 1'b1;
            wb_we_s    = reg_write_en_m;
          end else if (dmem_gnt) begin
            stall_s = 1'b1;
            state_d = ST_RESP;
          end else begin
            stall_s = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (tmo_hit_s) begin
          // request withdrawn; retire with an error
          state_d    = ST_IDLE;
          wb_valid_s = 1'b1;
          wb_err_s   = 1'b1;
        end else begin
          // upstream is stalled, so address/data/we are still stable
          req_s = 1'b1;
          if (dmem_gnt && dmem_write_en_m) begin
            state_d    = ST_IDLE;
            wb_valid_s = 1'b1;
            wb_we_s    = reg_write_en_m;
          end else if (dmem_gnt) begin
            stall_s = 1'b1;
            state_d = ST_RESP;
          end else begin
            stall_s = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          // a response arriving on the budget's last cycle still wins
          state_d    = ST_IDLE;
          wb_valid_s = 1'b1;
          wb_we_s    = reg_write_en_m;
          rdata_ld_s = 1'b1;
        end else if (tmo_hit_s) begin
          state_d    = ST_IDLE;
          wb_valid_s = 1'b1;
          wb_err_s   = 1'b1;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Timeout counter: counts cycles in REQ/RESP, zero whenever IDLE is (re)entered.
  always_comb begin
    tmo_cnt_d = 8'd0;
    if (state_d == ST_IDLE) begin
      tmo_cnt_d = 8'd0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_d = 8'd0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  // State and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // MEM/WB boundary: bubble while stalled, otherwise capture the retiring instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q             <= 1'b0;
      execute_out_q       <= 32'h0000_0000;
      dmem_readdata_q     <= 32'h0000_0000;
      reg_write_addr_q    <= 5'd0;
      reg_write_en_q      <= 1'b0;
      reg_writedata_sel_q <= 1'b0;
      mem_err_q           <= 1'b0;
    end else if (stall_s) begin
      valid_q        <= 1'b0;
      reg_write_en_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      valid_q             <= wb_valid_s;
      reg_write_en_q      <= wb_we_s;
      mem_err_q           <= wb_err_s;
      execute_out_q       <= execute_out_m;
      reg_write_addr_q    <= reg_write_addr_m;
      reg_writedata_sel_q <= reg_writedata_sel_m;
      if (rdata_ld_s) begin
        dmem_readdata_q <= dmem_rdata;
      end
    end
  end

  // Bus outputs are qualified by the request so an idle port reads as all zeros.
  always_comb begin
    stall_m    = stall_s;
    dmem_req   = req_s;
    dmem_we    = req_s & dmem_write_en_m;
    dmem_addr  = req_s ? {execute_out_m[31:2], 2'b00} : 32'h0000_0000;
    dmem_wdata = req_s ? reg_readdata2_m : 32'h0000_0000;
  end

  assign valid_w             = valid_q;
  assign execute_out_w       = execute_out_q;
  assign dmem_readdata_w     = dmem_readdata_q;
  assign reg_write_addr_w    = reg_write_addr_q;
  assign reg_write_en_w      = reg_write_en_q;
  assign reg_writedata_sel_w = reg_writedata_sel_q;
  assign mem_err_w           = mem_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed stimulus with a scoreboard; a monitor compares
// every MEM/WB retirement against the expected queue.
module tb_memory_stage;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m, flush_m;
  logic [31:0] execute_out_m, reg_readdata2_m;
  logic        dmem_read_en_m, dmem_write_en_m;
  logic [4:0]  reg_write_addr_m;
  logic        reg_write_en_m, reg_writedata_sel_m;
  logic        stall_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        valid_w;
  logic [31:0] execute_out_w, dmem_readdata_w;
  logic [4:0]  reg_write_addr_w;
  logic        reg_write_en_w, reg_writedata_sel_w, mem_err_w;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .valid_m(valid_m), .flush_m(flush_m),
    .execute_out_m(execute_out_m), .reg_readdata2_m(reg_readdata2_m),
    .dmem_read_en_m(dmem_read_en_m), .dmem_write_en_m(dmem_write_en_m),
    .reg_write_addr_m(reg_write_addr_m), .reg_write_en_m(reg_write_en_m),
    .reg_writedata_sel_m(reg_writedata_sel_m), .stall_m(stall_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .valid_w(valid_w), .execute_out_w(execute_out_w),
    .dmem_readdata_w(dmem_readdata_w), .reg_write_addr_w(reg_write_addr_w),
    .reg_write_en_w(reg_write_en_w), .reg_writedata_sel_w(reg_writedata_sel_w),
    .mem_err_w(mem_err_w)
  );

  typedef struct {
    logic [31:0] exec;
    logic [31:0] rdata;
    logic [4:0]  waddr;
    logic        we;
    logic        sel;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] exec, input logic [31:0] rdata,
                          input logic [4:0] waddr, input logic we, input logic sel,
                          input logic err);
    exp_t e;
    e.exec = exec; e.rdata = rdata; e.waddr = waddr; e.we = we; e.sel = sel; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic idle_in();
    valid_m = 1'b0; flush_m = 1'b0; execute_out_m = 32'h0; reg_readdata2_m = 32'h0;
    dmem_read_en_m = 1'b0; dmem_write_en_m = 1'b0; reg_write_addr_m = 5'd0;
    reg_write_en_m = 1'b0; reg_writedata_sel_m = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_stall"},  32'(stall_m), 32'h0);
    check({p, "_req"},    32'(dmem_req), 32'h0);
    check({p, "_we"},     32'(dmem_we), 32'h0);
    check({p, "_addr"},   dmem_addr, 32'h0);
    check({p, "_wdata"},  dmem_wdata, 32'h0);
    check({p, "_valid_w"}, 32'(valid_w), 32'h0);
    check({p, "_exec_w"}, execute_out_w, 32'h0);
    check({p, "_rdata_w"}, dmem_readdata_w, 32'h0);
    check({p, "_waddr_w"}, 32'(reg_write_addr_w), 32'h0);
    check({p, "_wen_w"},  32'(reg_write_en_w), 32'h0);
    check({p, "_sel_w"},  32'(reg_writedata_sel_w), 32'h0);
    check({p, "_err_w"},  32'(mem_err_w), 32'h0);
  endtask

  // Monitor: every retirement is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!rst) begin
      check("err_without_valid", 32'(mem_err_w & ~valid_w), 32'h0);
      if (valid_w) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid_w", 32'(valid_w), 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_exec",  execute_out_w, mon_e.exec);
          check("wb_rdata", dmem_readdata_w, mon_e.rdata);
          check("wb_waddr", 32'(reg_write_addr_w), 32'(mon_e.waddr));
          check("wb_wen",   32'(reg_write_en_w), 32'(mon_e.we));
          check("wb_sel",   32'(reg_writedata_sel_w), 32'(mon_e.sel));
          check("wb_err",   32'(mem_err_w), 32'(mon_e.err));
        end
      end
    end
  end

  // Non-memory op: one cycle, never stalls or requests. Caller is at posedge+1.
  task automatic alu_op(input string name, input logic [31:0] exec, input logic [4:0] wa,
                        input logic wen, input logic sel);
    valid_m = 1'b1; execute_out_m = exec; reg_write_addr_m = wa;
    reg_write_en_m = wen; reg_writedata_sel_m = sel;
    @(negedge clk);
    check({name, "_stall"}, 32'(stall_m), 32'h0);
    check({name, "_req"}, 32'(dmem_req), 32'h0);
    push_exp(exec, last_rdata, wa, wen, sel, 1'b0);
    @(posedge clk); #1;
    idle_in();
  endtask

  // Memory op with grant/rvalid on given cycle numbers (0 = never).
  task automatic mem_access(input string name, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] wa, input logic wen, input logic sel,
                            input int gnt_cyc, input int rv_cyc, input int flush_cyc,
                            input logic [31:0] rdata_v, input int exp_stall,
                            input logic exp_err);
    int   stalls = 0;
    logic done   = 1'b0;
    logic exp_req;
    logic [31:0] exp_rd;
    valid_m = 1'b1; dmem_read_en_m = rd; dmem_write_en_m = wr; execute_out_m = addr;
    reg_readdata2_m = wdata; reg_write_addr_m = wa; reg_write_en_m = wen;
    reg_writedata_sel_m = sel;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      dmem_gnt    = (cyc == gnt_cyc);
      dmem_rvalid = (cyc == rv_cyc);
      dmem_rdata  = (cyc == rv_cyc) ? rdata_v : 32'h0;
      flush_m     = (flush_cyc > 0) && (cyc >= flush_cyc);
      @(negedge clk);
      exp_req = (cyc <= gnt_cyc);
      check({name, "_req"}, 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        check({name, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({name, "_we"}, 32'(dmem_we), 32'(wr));
        if (wr) check({name, "_wdata"}, dmem_wdata, wdata);
      end
      if (!stall_m) begin
        done = 1'b1;
        if (rd && !wr && !exp_err) last_rdata = rdata_v;
        exp_rd = last_rdata;
        push_exp(addr, exp_rd, wa, exp_err ? 1'b0 : wen, sel, exp_err);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    idle_in();
    check({name, "_done"}, 32'(done), 32'h1);
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
  endtask

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    alu_op("alu1", 32'h0000_1234, 5'd5, 1'b1, 1'b0);
    //          name      rd    wr    addr          wdata         wa    wen   sel  gnt rv flush rdata        stall err
    mem_access("st_imm",  1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1, 0, 0, 32'h0,         0, 1'b0);
    alu_op("alu2", 32'h0000_0055, 5'd9, 1'b1, 1'b0);
    mem_access("ld_slow", 1'b1, 1'b0, 32'h0000_0200, 32'h0,         5'd7, 1'b1, 1'b1, 4, 6, 0, 32'hCAFE_F00D, 5, 1'b0);
    mem_access("ld_fast", 1'b1, 1'b0, 32'h0000_0300, 32'h0,         5'd8, 1'b1, 1'b1, 1, 2, 0, 32'h1122_3344, 1, 1'b0);
    mem_access("ld_mis",  1'b1, 1'b0, 32'h0000_0202, 32'h0,         5'd4, 1'b1, 1'b1, 0, 0, 0, 32'h0,         0, 1'b1);
    mem_access("both_en", 1'b1, 1'b1, 32'h0000_0600, 32'h0000_0001, 5'd6, 1'b1, 1'b0, 0, 0, 0, 32'h0,         0, 1'b1);
    mem_access("st_slow", 1'b0, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 3, 0, 2, 32'h0,         2, 1'b0);
    mem_access("ld_tmo",  1'b1, 1'b0, 32'h0000_0700, 32'h0,         5'd2, 1'b1, 1'b1, 1, 0, 0, 32'h0,         8, 1'b1);
    alu_op("alu3", 32'h0000_ABCD, 5'd10, 1'b1, 1'b1);

    // Flushed load in IDLE: no request, no retirement.
    valid_m = 1'b1; flush_m = 1'b1; dmem_read_en_m = 1'b1; execute_out_m = 32'h0000_0500;
    reg_write_en_m = 1'b1; reg_write_addr_m = 5'd11;
    @(negedge clk);
    check("flush_req", 32'(dmem_req), 32'h0);
    check("flush_stall", 32'(stall_m), 32'h0);
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    check("flush_valid_w", 32'(valid_w), 32'h0);
    check("flush_wen_w", 32'(reg_write_en_w), 32'h0);
    @(posedge clk); #1;

    // Reset while waiting for read data; a late rvalid must be ignored.
    valid_m = 1'b1; dmem_read_en_m = 1'b1; execute_out_m = 32'h0000_0400;
    reg_write_addr_m = 5'd3; reg_write_en_m = 1'b1; reg_writedata_sel_m = 1'b1; dmem_gnt = 1'b1;
    @(negedge clk);
    check("rstmid_stall", 32'(stall_m), 32'h1);
    check("rstmid_req", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_in();
    last_rdata = 32'h0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_all_zero("rstmid");
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    check("late_rvalid_rdata_w", dmem_readdata_w, 32'h0);
    check("late_rvalid_valid_w", 32'(valid_w), 32'h0);
    @(posedge clk); #1;
    alu_op("alu_after_rst", 32'h0000_7777, 5'd12, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
